// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a simple 32-bit datapath.
// It sequences fetch (T0-T2) and execute (T3-T6) steps and decodes every
// strobe combinationally from the current step and the instruction register.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        HIin,
    output logic        LOin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        IncPC,
    output logic        Read,
    output logic [12:0] alu_sel,
    output logic        done,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        K_BIN,
        K_UNARY,
        K_MULDIV,
        K_NOP,
        K_HALT,
        K_ILL
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind;
    logic [12:0] alu_bit;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic        unused_ir_bits;

    assign opcode         = ir[31:27];
    assign ra             = ir[26:23];
    assign rb             = ir[22:19];
    assign rc             = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];
    assign state          = state_q;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

    // Opcode decode: instruction class and the ALU function it selects
    always_comb begin
        kind    = K_ILL;
        alu_bit = '0;
        case (opcode)
            5'b00000: begin kind = K_BIN;    alu_bit[0]  = 1'b1; end // ADD
            5'b00001: begin kind = K_BIN;    alu_bit[1]  = 1'b1; end // SUB
            5'b00010: begin kind = K_BIN;    alu_bit[2]  = 1'b1; end // AND
            5'b00011: begin kind = K_BIN;    alu_bit[3]  = 1'b1; end // OR
            5'b00100: begin kind = K_BIN;    alu_bit[7]  = 1'b1; end // ROR
            5'b00101: begin kind = K_BIN;    alu_bit[8]  = 1'b1; end // ROL
            5'b00110: begin kind = K_BIN;    alu_bit[4]  = 1'b1; end // SHR
            5'b00111: begin kind = K_BIN;    alu_bit[5]  = 1'b1; end // SHRA
            5'b01000: begin kind = K_BIN;    alu_bit[6]  = 1'b1; end // SHL
            5'b01111: begin kind = K_MULDIV; alu_bit[11] = 1'b1; end // MUL
            5'b10000: begin kind = K_MULDIV; alu_bit[12] = 1'b1; end // DIV
            5'b10001: begin kind = K_UNARY;  alu_bit[9]  = 1'b1; end // NEG
            5'b10010: begin kind = K_UNARY;  alu_bit[10] = 1'b1; end // NOT
            5'b11010: kind = K_NOP;
            5'b11011: kind = K_HALT;
            default:  kind = K_ILL;
        endcase
    end

    // Step sequencing and strobe decode; every strobe defaults low
    always_comb begin
        state_d  = state_q;
        reg_in   = '0;
        reg_out  = '0;
        alu_sel  = '0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        done     = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IDLE: state_d = run ? S_T0 : S_IDLE;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (kind)
                    K_BIN: begin
                        reg_out = onehot16(rb);
                        Yin     = 1'b1;
                    end
                    K_MULDIV: begin
                        reg_out = onehot16(ra);
                        Yin     = 1'b1;
                    end
                    K_NOP: begin
                        done    = 1'b1;
                        state_d = run ? S_T0 : S_IDLE;
                    end
                    K_HALT: begin
                        done    = 1'b1;
                        state_d = S_HALTED;
                    end
                    K_ILL: begin
                        illegal = 1'b1;
                        done    = 1'b1;
                        state_d = run ? S_T0 : S_IDLE;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                // Binary ops take their second operand from Rc; unary and MUL/DIV from Rb
                reg_out = (kind == K_BIN) ? onehot16(rc) : onehot16(rb);
                alu_sel = alu_bit;
                Zin     = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (kind == K_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    reg_in  = onehot16(ra);
                    done    = 1'b1;
                    state_d = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = run ? S_T0 : S_IDLE;
            end
            S_HALTED: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // Step register; clear returns to IDLE immediately
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a stimulus process drives instructions and
// pushes the per-cycle expected outputs; a monitor pops and compares them.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic [15:0] reg_in, reg_out;
    logic        PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic        IncPC, Read, done, halted, illegal;
    logic [12:0] alu_sel;
    logic [3:0]  state;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir),
        .reg_in(reg_in), .reg_out(reg_out),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .IncPC(IncPC), .Read(Read),
        .alu_sel(alu_sel), .done(done), .halted(halted), .illegal(illegal),
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [12:0] alu;
        logic [18:0] fl;
    } obs_t;

    localparam int F_PCIN = 0, F_IRIN = 1, F_YIN = 2, F_ZIN = 3, F_MARIN = 4;
    localparam int F_MDRIN = 5, F_HIIN = 6, F_LOIN = 7, F_PCOUT = 8, F_MDROUT = 9;
    localparam int F_ZHI = 10, F_ZLO = 11, F_INCPC = 14, F_READ = 15;
    localparam int F_DONE = 16, F_HALTED = 17, F_ILL = 18;

    obs_t act;
    assign act = {state, reg_in, reg_out, alu_sel,
                  illegal, halted, done, Read, IncPC, LOout, HIout, Zlowout,
                  Zhighout, MDRout, PCout, LOin, HIin, MDRin, MARin, Zin, Yin,
                  IRin, PCin};

    obs_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_st;
    logic [31:0] cur_instr;

    // Instruction classes: 0 binary, 1 unary, 2 mul/div, 3 nop, 4 halt, 5 illegal
    function automatic void decode(input logic [4:0] op, output int k, output int ab);
        k  = 5;
        ab = 0;
        case (op)
            5'd0:  begin k = 0; ab = 0;  end
            5'd1:  begin k = 0; ab = 1;  end
            5'd2:  begin k = 0; ab = 2;  end
            5'd3:  begin k = 0; ab = 3;  end
            5'd4:  begin k = 0; ab = 7;  end
            5'd5:  begin k = 0; ab = 8;  end
            5'd6:  begin k = 0; ab = 4;  end
            5'd7:  begin k = 0; ab = 5;  end
            5'd8:  begin k = 0; ab = 6;  end
            5'd15: begin k = 2; ab = 11; end
            5'd16: begin k = 2; ab = 12; end
            5'd17: begin k = 1; ab = 9;  end
            5'd18: begin k = 1; ab = 10; end
            5'd26: k = 3;
            5'd27: k = 4;
            default: k = 5;
        endcase
    endfunction

    // State code of the final step of an instruction
    function automatic int last_step(input logic [31:0] instr);
        int k, ab;
        decode(instr[31:27], k, ab);
        if (k <= 1) return 6;
        if (k == 2) return 7;
        return 4;
    endfunction

    function automatic obs_t expect_at(input int st, input logic [31:0] instr);
        obs_t e;
        int k, ab;
        logic [3:0] ra, rb, rc;
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        decode(instr[31:27], k, ab);
        e    = '0;
        e.st = 4'(st);
        case (st)
            1: begin e.fl[F_PCOUT] = 1'b1; e.fl[F_MARIN] = 1'b1; e.fl[F_INCPC] = 1'b1; e.fl[F_ZIN] = 1'b1; end
            2: begin e.fl[F_ZLO] = 1'b1; e.fl[F_PCIN] = 1'b1; e.fl[F_READ] = 1'b1; e.fl[F_MDRIN] = 1'b1; end
            3: begin e.fl[F_MDROUT] = 1'b1; e.fl[F_IRIN] = 1'b1; end
            4: begin
                if (k == 0) begin e.rout[rb] = 1'b1; e.fl[F_YIN] = 1'b1; end
                if (k == 2) begin e.rout[ra] = 1'b1; e.fl[F_YIN] = 1'b1; end
                if (k >= 3) e.fl[F_DONE] = 1'b1;
                if (k == 5) e.fl[F_ILL] = 1'b1;
            end
            5: begin
                if (k == 0) e.rout[rc] = 1'b1;
                else        e.rout[rb] = 1'b1;
                e.alu[ab]     = 1'b1;
                e.fl[F_ZIN]   = 1'b1;
            end
            6: begin
                e.fl[F_ZLO] = 1'b1;
                if (k == 2) e.fl[F_LOIN] = 1'b1;
                else begin e.rin[ra] = 1'b1; e.fl[F_DONE] = 1'b1; end
            end
            7: begin e.fl[F_ZHI] = 1'b1; e.fl[F_HIIN] = 1'b1; e.fl[F_DONE] = 1'b1; end
            8: e.fl[F_HALTED] = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic int next_step(input int st, input bit run_v, input logic [31:0] instr);
        int k, ab;
        decode(instr[31:27], k, ab);
        if (st == 0) return run_v ? 1 : 0;
        if (st == 8) return 8;
        if (st < 4) return st + 1;
        if (st == last_step(instr)) return (k == 4) ? 8 : (run_v ? 1 : 0);
        return st + 1;
    endfunction

    // One clock cycle of stimulus; clr_n=0 pulls clear low mid-cycle
    task automatic cycle(input bit run_v, input bit clr_n);
        @(posedge clock);
        #1;
        run   = run_v;
        clear = clr_n;
        ir    = (m_st >= 4 && m_st <= 7) ? cur_instr : $urandom();
        if (!clr_n) begin
            sb.push_back(expect_at(0, cur_instr));
            m_st = 0;
        end else begin
            sb.push_back(expect_at(m_st, cur_instr));
            m_st = next_step(m_st, run_v, cur_instr);
        end
    endtask

    task automatic do_instr(input logic [31:0] instr, input bit run_done, input int clr_at);
        cur_instr = instr;
        if (m_st == 0) cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (m_st == clr_at) begin
                cycle(bit'($urandom_range(0, 1)), 1'b0);
                return;
            end
            if (m_st == last_step(instr)) begin
                cycle(run_done, 1'b1);
                return;
            end
            cycle(bit'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    // Monitor: compare one expected record per cycle, away from the clock edge
    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                obs_t e;
                e = sb.pop_front();
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL cycle_outputs t=%0t got st=%0d rin=%h rout=%h alu=%h fl=%h want st=%0d rin=%h rout=%h alu=%h fl=%h",
                             $time, act.st, act.rin, act.rout, act.alu, act.fl,
                             e.st, e.rin, e.rout, e.alu, e.fl);
                end
            end
        end
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] rnd;
        int          clr_at;
        bit          run_done;
        clear     = 1'b0;
        run       = 1'b0;
        ir        = '0;
        m_st      = 0;
        cur_instr = '0;

        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        do_instr(32'h112B0000, 1'b1, -1);
        do_instr({5'b01111, 4'd3, 4'd4, 19'd0}, 1'b1, -1);
        do_instr({5'b11111, 27'd0}, 1'b1, -1);
        do_instr({5'b00000, 4'd7, 4'd8, 4'd9, 15'd0}, 1'b1, 5);
        do_instr({5'b10010, 4'd1, 4'd2, 19'd0}, 1'b0, -1);
        repeat (4) cycle(1'b0, 1'b1);
        do_instr({5'b00001, 4'd0, 4'd0, 4'd0, 15'd0}, 1'b1, -1);
        do_instr({5'b10000, 4'd15, 4'd15, 19'd0}, 1'b1, -1);
        do_instr({5'b11010, 27'd0}, 1'b0, -1);

        for (int n = 0; n < 80; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            rnd      = $urandom();
            clr_at   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : -1;
            run_done = ($urandom_range(0, 3) != 0);
            do_instr({op, rnd[26:0]}, run_done, clr_at);
            if (m_st == 0) repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b1);
        end

        do_instr({5'b11011, 27'd0}, 1'b1, -1);
        repeat (10) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);

        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clock, clear.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 clear  in  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 run  in  1  level; 1 permits fetch of the next instruction.
REQ-005 ir  in  32  instruction register from the datapath: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-006 reg_in  out  16  one-hot GPR load strobes; bit n maps to Rnin.
REQ-007 reg_out  out  16  one-hot GPR bus drivers; bit n maps to Rnout.
REQ-008 PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin  out  1 each  register load strobes.
REQ-009 PCout, MDRout, Zhighout, Zlowout, HIout, LOout  out  1 each  bus drive strobes.
REQ-010 IncPC, Read  out  1 each  PC-increment ALU select; memory read.
REQ-011 alu_sel  out  13  one-hot: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV.
REQ-012 done  out  1  one-cycle pulse in final step of each instruction.
REQ-013 halted  out  1  level, high while in HALTED.
REQ-014 illegal  out  1  one-cycle pulse on undefined opcode.
REQ-015 state  out  4  current state code, for debug.

Function
REQ-016 States SHALL be IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALTED=8; state register updates on rising clock edge only.
REQ-017 All outputs SHALL be a combinational decode of state and ir; every strobe not listed for a state is 0; at most one bus driver is high in any state.
REQ-018 IDLE: no strobes; -> T0 when run=1, else stay.
REQ-019 T0: PCout, MARin, IncPC, Zin; -> T1.
REQ-020 T1: Zlowout, PCin, Read, MDRin; -> T2.
REQ-021 T2: MDRout, IRin; -> T3 after decode of the ir value loaded at this edge.
REQ-022 Opcodes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 ROR, 00101 ROL, 00110 SHR, 00111 SHRA, 01000 SHL, 01111 MUL, 10000 DIV, 10001 NEG, 10010 NOT, 11010 NOP, 11011 HALT; all others illegal.
REQ-023 Binary ALU ops (ADD..SHL): T3 reg_out[Rb], Yin; T4 reg_out[Rc], matching alu_sel bit, Zin; T5 Zlowout, reg_in[Ra], done.
REQ-024 NEG/NOT: T3 no strobes; T4 reg_out[Rb], alu_sel bit, Zin; T5 Zlowout, reg_in[Ra], done.
REQ-025 MUL/DIV: T3 reg_out[Ra], Yin; T4 reg_out[Rb], alu_sel bit, Zin; T5 Zlowout, LOin; T6 Zhighout, HIin, done.
REQ-026 NOP: T3 done, no other strobes. HALT: T3 done -> HALTED. Illegal: T3 illegal, done, no register writes.
REQ-027 After the done state: -> T0 if run=1, else -> IDLE; run is sampled only in IDLE and done states.
REQ-028 HALTED: all strobes 0, halted=1; exits only via clear.
REQ-029 Ra/Rb/Rc=0 SHALL address R0 like any other register; Ra equal to Rb or Rc is legal.

Reset
REQ-030 clear=0 SHALL force state=IDLE and all outputs to 0 asynchronously, including mid-instruction; no partial register write completes after assertion.
REQ-031 After clear deasserts, first fetch starts on the first rising edge with run=1.

Verification
REQ-032 ir=0x112B0000 (AND R2,R5,R6), run=1: T3 reg_out=0x0020,Yin; T4 reg_out=0x0040, alu_sel=0x0004, Zin; T5 reg_in=0x0004, Zlowout, done.
REQ-033 ir=0x78000000-form MUL R3,R4 (opcode 01111, Ra=3, Rb=4): T3 reg_out=0x0008; T4 reg_out=0x0010, alu_sel=0x0800; T5 LOin; T6 HIin, done.
REQ-034 opcode 11011 HALT: done at T3, then halted=1 and state=8 held for 10 cycles with run=1.
REQ-035 opcode 11111: illegal and done pulse at T3, reg_in stays 0, next state T0 with run=1.
REQ-036 clear=0 asserted during T4 of an ADD: state=0 and all strobes 0 before next edge; run=1 after release -> T0 one edge later.
REQ-037 run=0 at T5 of NOT R1,R2: done pulse then IDLE; all strobes 0 until run=1.
